stream_read_sequencer: RTL and testbench
========================================

Name: stream_read_sequencer

Overview:
- Read-side counterpart of the streaming register file (SRF).
- Accepts a read request (stream ID, beat count) and drives the SRF read stream ID for that many cycles.
- Captures the SRF's registered output (1-cycle read latency) into a small credit-controlled FIFO, then delivers the vectors to a consuming functional slice over a valid/ready interface.
- Sits between the SRF and a slice's operand input; one request is in service at a time.

Parameters:
NUM_STREAM_ID, 5, width of the stream ID (addresses 32 stream registers)
MIN_VEC_LENGTH, 16, bits per tile lane
NUM_TILES_PER_SLICE, 20, lanes per vector
FIFO_DEPTH, 4, output buffer entries (power of two, >=2)
LEN_W, 8, width of the beat-count field

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
req_valid  in  1  request offered
req_ready  out  1  request accepted when req_valid && req_ready
req_stream_id  in  NUM_STREAM_ID  stream to read
req_length  in  LEN_W  number of beats to read (0 allowed)
srf_stream_id  out  NUM_STREAM_ID  read address to SRF
srf_rd_en  out  1  marks a cycle whose SRF result must be captured
srf_data  in  MIN_VEC_LENGTH x NUM_TILES_PER_SLICE (unpacked array)  SRF data, valid 1 cycle after srf_stream_id
out_valid  out  1  out_data/out_last valid
out_ready  in  1  consumer accepts the beat
out_data  out  MIN_VEC_LENGTH x NUM_TILES_PER_SLICE  vector beat
out_last  out  1  final beat of the request
busy  out  1  request in service
done  out  1  one-cycle pulse when a request fully completes

Behaviour:
- Reset (rst==0 at posedge) forces:
  - state IDLE; FIFO flushed; outstanding counter 0; capture pipeline bit 0.
  - out_valid 0, out_last 0, srf_rd_en 0, srf_stream_id 0, busy 0, done 0.
  - req_ready is 0 while rst==0 and 1 in IDLE otherwise.
  - A reset mid-request abandons the request; no stale SRF capture may enter the FIFO after reset deasserts.
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE:
  - req_ready=1, busy=0.
  - On handshake, latch id and remaining=req_length.
  - If req_length==0, go to DRAIN, emit no beats, and pulse done when DRAIN exits.
  - Otherwise go to ISSUE.
- ISSUE:
  - busy=1; srf_stream_id=latched id (held constant).
  - Each cycle where outstanding<FIFO_DEPTH: assert srf_rd_en, increment outstanding, decrement remaining.
  - Tag the issue as last when remaining==1; after the last issue go to DRAIN.
  - If outstanding==FIFO_DEPTH, srf_rd_en=0 and nothing is issued that cycle (stall).
- DRAIN: busy=1; no issue; when FIFO empty and outstanding==0, pulse done for 1 cycle and go to IDLE.
- Capture: the srf_rd_en and last tag are registered one cycle. In the following cycle, push srf_data with the tag into the FIFO. The credit scheme guarantees the FIFO never overflows.
- outstanding counter:
  - Counts occupancy plus reads in flight; range 0..FIFO_DEPTH.
  - Increments on issue, decrements on pop (out_valid && out_ready).
  - Simultaneous issue and pop leave it unchanged.
- Output:
  - out_valid = FIFO not empty; out_data/out_last = head entry.
  - The beat holds stable while out_valid && !out_ready.
  - Pop on out_valid && out_ready.
- Latency: handshake accepted at edge E0 → srf_rd_en at cycle E0+1 → FIFO push at E0+2 edge → out_valid earliest cycle E0+3.
- Throughput: one beat per cycle with out_ready held high.
- The SRF content is sampled at each issue cycle. If a writer updates the stream mid-request, later beats reflect the new data.
- Next request is accepted only after done (req_ready low from acceptance through the done cycle).
- Backpressure from out_ready never drops or duplicates beats. Beat count delivered equals req_length exactly.

Test Plan:
- Reset, then request id=3, len=4; SRF stream 3 preloaded with lane values 0x0300+lane; out_ready=1 → out_valid at acceptance+3, 4 consecutive beats, out_last on beat 4 only, done pulse 1 cycle after the last pop, req_ready returns to 1.
- id=7, len=10, out_ready=0 for 8 cycles → srf_rd_en stops after 4 issues, outstanding=4, out_data stable; then out_ready=1 → all 10 beats delivered in order, none lost or duplicated.
- len=0 → no out_valid, no srf_rd_en, done pulses, back to IDLE within 2 cycles.
- id=1, len=6 with the writer changing stream 1 from 0xAAAA to 0x5555 at issue 3 → beats 1–3 carry 0xAAAA and beats 4–6 carry 0x5555, matching per-cycle sampling.
- Assert rst=0 mid-request (after 2 beats popped, FIFO non-empty) → next cycle out_valid=0, busy=0, srf_rd_en=0. After release, a new request id=2, len=2 yields exactly 2 beats of stream 2 data.
- Random out_ready (50%) over 20 back-to-back requests with random id/len → scoreboard matches exact beat counts, order, and out_last placement.

Source files
------------

// File: rtl/stream_read_sequencer.sv
// Read-side sequencer for the streaming register file: issues SRF reads for a
// requested beat count and returns the vectors to a slice over valid/ready.
module stream_read_sequencer #(
  parameter int NUM_STREAM_ID       = 5,
  parameter int MIN_VEC_LENGTH      = 16,
  parameter int NUM_TILES_PER_SLICE = 20,
  parameter int FIFO_DEPTH          = 4,
  parameter int LEN_W               = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [NUM_STREAM_ID-1:0]  req_stream_id,
  input  logic [LEN_W-1:0]          req_length,
  output logic [NUM_STREAM_ID-1:0]  srf_stream_id,
  output logic                      srf_rd_en,
  input  logic [MIN_VEC_LENGTH-1:0] srf_data [NUM_TILES_PER_SLICE],
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [MIN_VEC_LENGTH-1:0] out_data [NUM_TILES_PER_SLICE],
  output logic                      out_last,
  output logic                      busy,
  output logic                      done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [NUM_STREAM_ID-1:0] id_q;
  logic [LEN_W-1:0]         remaining_q;
  logic [CNT_W-1:0]         outstanding_q;

  logic cap_vld_p0;
  logic cap_last_p0;

  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  logic [MIN_VEC_LENGTH-1:0] data_mem [FIFO_DEPTH][NUM_TILES_PER_SLICE];
  logic                      last_mem [FIFO_DEPTH];

  logic accept;
  logic can_issue;
  logic issue;
  logic issue_last;
  logic push;
  logic pop;
  logic fifo_empty;
  logic drained;

  // outstanding counts FIFO occupancy plus reads still in the capture pipe,
  // so bounding it by FIFO_DEPTH is the whole overflow protection.
  assign accept     = req_valid && req_ready;
  assign can_issue  = outstanding_q < CNT_W'(FIFO_DEPTH);
  assign issue      = (state_q == ISSUE) && can_issue;
  assign issue_last = issue && (remaining_q == LEN_W'(1));
  assign fifo_empty = (count_q == '0);
  assign drained    = (outstanding_q == '0) && fifo_empty;
  assign push       = cap_vld_p0;
  assign pop        = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = (req_length == '0) ? DRAIN : ISSUE;
        end
      end
      ISSUE: begin
        if (issue_last) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (drained) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready     = 1'b0;
    busy          = 1'b0;
    srf_rd_en     = 1'b0;
    srf_stream_id = '0;
    done          = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = rst;
      end
      ISSUE: begin
        busy          = 1'b1;
        srf_stream_id = id_q;
        srf_rd_en     = can_issue;
      end
      DRAIN: begin
        busy          = 1'b1;
        srf_stream_id = id_q;
        done          = drained;
      end
      default: begin
        req_ready = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      id_q        <= '0;
      remaining_q <= '0;
    end else if (accept) begin
      id_q        <= req_stream_id;
      remaining_q <= req_length;
    end else if (issue) begin
      remaining_q <= remaining_q - LEN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      outstanding_q <= '0;
    end else begin
      unique case ({issue, pop})
        2'b10:   outstanding_q <= outstanding_q + CNT_W'(1);
        2'b01:   outstanding_q <= outstanding_q - CNT_W'(1);
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

  // ---- stage p0: SRF read issued last cycle, its data arrives this cycle ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      cap_vld_p0  <= 1'b0;
      cap_last_p0 <= 1'b0;
    end else begin
      cap_vld_p0  <= issue;
      cap_last_p0 <= issue_last;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_q] <= srf_data;
      last_mem[wr_ptr_q] <= cap_last_p0;
    end
  end

  // ---- output stage: FIFO head presented to the slice ----
  assign out_valid = !fifo_empty;
  assign out_data  = data_mem[rd_ptr_q];
  assign out_last  = !fifo_empty && last_mem[rd_ptr_q];

endmodule

// File: tb/tb_stream_read_sequencer.sv
// Directed and randomized bench for stream_read_sequencer with an SRF model
// and a beat scoreboard.
module tb_stream_read_sequencer;

  localparam int SID_W = 5;
  localparam int LANE_W = 16;
  localparam int LANES = 20;
  localparam int DEPTH = 4;
  localparam int LEN_W = 8;
  localparam int VEC_W = LANE_W * LANES;

  typedef struct packed {
    logic             last;
    logic [VEC_W-1:0] data;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [SID_W-1:0]  req_stream_id = '0;
  logic [LEN_W-1:0]  req_length = '0;
  logic [SID_W-1:0]  srf_stream_id;
  logic              srf_rd_en;
  logic [LANE_W-1:0] srf_data [LANES];
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [LANE_W-1:0] out_data [LANES];
  logic              out_last;
  logic              busy;
  logic              done;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int pop_cnt = 0;
  int last_pop_cyc = 0;
  int done_cyc = 0;
  logic wr_mode = 1'b0;
  int wr_cnt = 0;
  beat_t exp_q[$];
  logic [VEC_W-1:0] out_flat;

  always #5 clk = ~clk;

  stream_read_sequencer #(
    .NUM_STREAM_ID(SID_W), .MIN_VEC_LENGTH(LANE_W), .NUM_TILES_PER_SLICE(LANES),
    .FIFO_DEPTH(DEPTH), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_stream_id(req_stream_id), .req_length(req_length),
    .srf_stream_id(srf_stream_id), .srf_rd_en(srf_rd_en), .srf_data(srf_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always_comb begin
    out_flat = '0;
    for (int l = 0; l < LANES; l++) out_flat[l*LANE_W +: LANE_W] = out_data[l];
  end

  function automatic logic [LANE_W-1:0] word(input logic [SID_W-1:0] s, input int l);
    return {3'b000, s, 8'(l)};
  endfunction

  function automatic logic [VEC_W-1:0] pat(input logic [SID_W-1:0] s);
    logic [VEC_W-1:0] v;
    for (int l = 0; l < LANES; l++) v[l*LANE_W +: LANE_W] = word(s, l);
    return v;
  endfunction

  function automatic logic [VEC_W-1:0] fill(input logic [LANE_W-1:0] w);
    logic [VEC_W-1:0] v;
    for (int l = 0; l < LANES; l++) v[l*LANE_W +: LANE_W] = w;
    return v;
  endfunction

  // SRF model: registered read, stream 1 rewritten after its third read when wr_mode is set
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!wr_mode) wr_cnt <= 0;
    else if (srf_rd_en && srf_stream_id == 5'd1) wr_cnt <= wr_cnt + 1;
    for (int l = 0; l < LANES; l++)
      srf_data[l] <= (wr_mode && srf_stream_id == 5'd1) ?
                     ((wr_cnt < 3) ? 16'hAAAA : 16'h5555) : word(srf_stream_id, l);
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %b, want %b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic [VEC_W:0] obs, input logic [VEC_W:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    beat_t e;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        assert (exp_q.size() != 0) else begin
          fails++;
          $error("FAIL extra_beat: got %0h, want no beat", {out_last, out_flat});
        end
      end else begin
        e = exp_q.pop_front();
        chk_beat($sformatf("beat%0d", pop_cnt), {out_last, out_flat}, e);
      end
      pop_cnt++;
      last_pop_cyc = cyc;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beats(input logic [SID_W-1:0] s, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.last = (i == len - 1);
      b.data = pat(s);
      exp_q.push_back(b);
    end
  endtask

  task automatic send_req(input logic [SID_W-1:0] s, input logic [LEN_W-1:0] len, input bit rnd);
    logic acc;
    acc = 1'b0;
    req_stream_id = s;
    req_length = len;
    req_valid = 1'b1;
    for (int k = 0; k < 50 && !acc; k++) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (req_ready === 1'b1) acc = 1'b1;
      step();
    end
    req_valid = 1'b0;
    chk1("req_accept", acc, 1'b1);
  endtask

  task automatic wait_done(input string tag, input int bound, input bit rnd);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < bound && !seen; k++) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        done_cyc = cyc;
      end
      step();
    end
    chk1({tag, "_done"}, seen, 1'b1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int iss;
    int base;
    logic [VEC_W-1:0] head;
    beat_t b;
    logic [SID_W-1:0] rid;
    logic [LEN_W-1:0] rlen;

    // reset state
    step(); step(); step();
    @(negedge clk);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_out_last", out_last, 1'b0);
    chk1("rst_rd_en", srf_rd_en, 1'b0);
    chkw("rst_stream_id", 32'(srf_stream_id), 0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_req_ready", req_ready, 1'b0);
    rst = 1'b1;
    step();
    @(negedge clk);
    chk1("idle_req_ready", req_ready, 1'b1);
    step();

    // basic request: latency, last placement, done timing
    out_ready = 1'b1;
    push_beats(5'd3, 4);
    send_req(5'd3, 8'd4, 1'b0);
    @(negedge clk);
    chk1("t1_rd_en_c1", srf_rd_en, 1'b1);
    chkw("t1_stream_id", 32'(srf_stream_id), 3);
    chk1("t1_busy", busy, 1'b1);
    chk1("t1_req_ready_low", req_ready, 1'b0);
    chk1("t1_valid_c1", out_valid, 1'b0);
    step();
    @(negedge clk);
    chk1("t1_valid_c2", out_valid, 1'b0);
    step();
    @(negedge clk);
    chk1("t1_valid_c3", out_valid, 1'b1);
    step();
    wait_done("t1", 20, 1'b0);
    chkw("t1_done_after_pop", 32'(done_cyc - last_pop_cyc), 1);
    @(negedge clk);
    chk1("t1_done_pulse", done, 1'b0);
    chk1("t1_req_ready_back", req_ready, 1'b1);
    step();
    chkw("t1_all_beats", 32'(exp_q.size()), 0);

    // backpressure: credit stall after DEPTH issues
    out_ready = 1'b0;
    push_beats(5'd7, 10);
    send_req(5'd7, 8'd10, 1'b0);
    iss = 0;
    head = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (srf_rd_en === 1'b1) iss++;
      if (k == 3) begin
        chk1("t2_valid_c3", out_valid, 1'b1);
        head = out_flat;
      end
      if (k == 8) begin
        chk_beat("t2_head_stable", {1'b0, out_flat}, {1'b0, head});
        chk1("t2_valid_held", out_valid, 1'b1);
        chk1("t2_rd_en_stalled", srf_rd_en, 1'b0);
      end
      step();
    end
    chkw("t2_issues", 32'(iss), DEPTH);
    out_ready = 1'b1;
    wait_done("t2", 60, 1'b0);
    chkw("t2_all_beats", 32'(exp_q.size()), 0);

    // zero-length request
    send_req(5'd9, 8'd0, 1'b0);
    @(negedge clk);
    chk1("t3_done", done, 1'b1);
    chk1("t3_rd_en", srf_rd_en, 1'b0);
    chk1("t3_valid", out_valid, 1'b0);
    step();
    @(negedge clk);
    chk1("t3_busy", busy, 1'b0);
    chk1("t3_req_ready", req_ready, 1'b1);
    step();

    // stream rewritten after the third read
    wr_mode = 1'b1;
    for (int i = 0; i < 6; i++) begin
      b.last = (i == 5);
      b.data = fill((i < 3) ? 16'hAAAA : 16'h5555);
      exp_q.push_back(b);
    end
    send_req(5'd1, 8'd6, 1'b0);
    wait_done("t4", 30, 1'b0);
    wr_mode = 1'b0;
    chkw("t4_all_beats", 32'(exp_q.size()), 0);

    // reset in the middle of a request
    push_beats(5'd5, 8);
    base = pop_cnt;
    send_req(5'd5, 8'd8, 1'b0);
    for (int k = 0; k < 30 && (pop_cnt - base) < 2; k++) step();
    chkw("t5_popped_before_rst", 32'(pop_cnt - base), 2);
    out_ready = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk1("t5_fifo_nonempty", out_valid, 1'b1);
    step();
    @(negedge clk);
    chk1("t5_rst_valid", out_valid, 1'b0);
    chk1("t5_rst_busy", busy, 1'b0);
    chk1("t5_rst_rd_en", srf_rd_en, 1'b0);
    chk1("t5_rst_req_ready", req_ready, 1'b0);
    rst = 1'b1;
    exp_q.delete();
    for (int k = 0; k < 4; k++) begin
      step();
      @(negedge clk);
      chk1("t5_no_stale", out_valid, 1'b0);
    end
    step();
    out_ready = 1'b1;
    push_beats(5'd2, 2);
    base = pop_cnt;
    send_req(5'd2, 8'd2, 1'b0);
    wait_done("t5", 30, 1'b0);
    chkw("t5_beat_count", 32'(pop_cnt - base), 2);
    chkw("t5_all_beats", 32'(exp_q.size()), 0);

    // back-to-back random requests with random backpressure
    for (int r = 0; r < 20; r++) begin
      rid = SID_W'($urandom_range(0, 31));
      rlen = LEN_W'($urandom_range(0, 9));
      push_beats(rid, int'(rlen));
      base = pop_cnt;
      send_req(rid, rlen, 1'b1);
      wait_done("t6", 300, 1'b1);
      chkw("t6_beat_count", 32'(pop_cnt - base), 32'(rlen));
      chkw("t6_q_empty", 32'(exp_q.size()), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
